// File: rtl/uart_tx_tick.sv
// Tick-paced UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert a parity bit between the data bits and the stop bit(s).
module uart_tx_tick #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx_out,
    output logic                 frame_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int STP_W = $clog2(STOP_BITS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic [STP_W-1:0] LAST_STOP = STP_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_idx;
    logic [STP_W-1:0]     r_stop_cnt;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_done;

`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
    // Parity is captured at accept because the shift register is consumed during DATA.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (r_state == S_IDLE && valid_in && r_ready) begin
            r_parity <= (^data_in) ^ (PARITY_ODD != 0);
        end
    end
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_cnt <= '0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Ticks are ignored here, including one coinciding with accept.
                    if (valid_in && r_ready) begin
                        r_shift    <= data_in;
                        r_idx      <= '0;
                        r_stop_cnt <= '0;
                        r_ready    <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (r_idx < LAST_IDX) begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + 1'b1;
                        end else begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx       <= 1'b1;
                            r_stop_cnt <= '0;
                            r_state    <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= '0;
                        r_state    <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_out  = r_ready;
    assign tx_out     = r_tx;
    assign frame_done = r_done;

endmodule
